// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register with the architectural HI/LO pair and a retired-instruction counter.
// The regfile write port is driven from WB; HI/LO reads are write-through from the WB slot.
module mem_wb_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic [DATA_W-1:0] hi_rd,
  output logic [DATA_W-1:0] lo_rd,
  output logic [CNT_W-1:0]  instret
);

  logic              wb_valid_reg, wb_valid_next;
  logic [ADDR_W-1:0] wb_wd_reg,    wb_wd_next;
  logic              wb_wreg_reg,  wb_wreg_next;
  logic [DATA_W-1:0] wb_wdata_reg, wb_wdata_next;
  logic              wb_whilo_reg, wb_whilo_next;
  logic [DATA_W-1:0] wb_hi_reg,    wb_hi_next;
  logic [DATA_W-1:0] wb_lo_reg,    wb_lo_next;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic [CNT_W-1:0]  instret_reg;

  logic load_bubble;
  logic load_capture;

  // Flush beats the WB hold; an invalid MEM slot is captured as a bubble so
  // its enables never reach the regfile or HI/LO.
  always_comb begin
    load_bubble  = flush || (!stall_wb && (stall_mem || !mem_valid));
    load_capture = !flush && !stall_wb && !stall_mem && mem_valid;
  end

  always_comb begin
    wb_valid_next = wb_valid_reg;
    wb_wd_next    = wb_wd_reg;
    wb_wreg_next  = wb_wreg_reg;
    wb_wdata_next = wb_wdata_reg;
    wb_whilo_next = wb_whilo_reg;
    wb_hi_next    = wb_hi_reg;
    wb_lo_next    = wb_lo_reg;
    if (load_bubble) begin
      wb_valid_next = 1'b0;
      wb_wd_next    = '0;
      wb_wreg_next  = 1'b0;
      wb_wdata_next = '0;
      wb_whilo_next = 1'b0;
      wb_hi_next    = '0;
      wb_lo_next    = '0;
    end else if (load_capture) begin
      wb_valid_next = 1'b1;
      wb_wd_next    = mem_wd;
      wb_wreg_next  = mem_wreg;
      wb_wdata_next = mem_wdata;
      wb_whilo_next = mem_whilo;
      wb_hi_next    = mem_hi;
      wb_lo_next    = mem_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_reg <= 1'b0;
      wb_wd_reg    <= '0;
      wb_wreg_reg  <= 1'b0;
      wb_wdata_reg <= '0;
      wb_whilo_reg <= 1'b0;
      wb_hi_reg    <= '0;
      wb_lo_reg    <= '0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      wb_wd_reg    <= wb_wd_next;
      wb_wreg_reg  <= wb_wreg_next;
      wb_wdata_reg <= wb_wdata_next;
      wb_whilo_reg <= wb_whilo_next;
      wb_hi_reg    <= wb_hi_next;
      wb_lo_reg    <= wb_lo_next;
    end
  end

  // Commit is independent of stall/flush: a held slot rewrites the same
  // values, and a flush only replaces what enters WB next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (wb_whilo_reg) begin
      hi_reg <= wb_hi_reg;
      lo_reg <= wb_lo_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_reg <= '0;
    end else if (wb_valid_reg && !stall_wb) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    hi_rd = wb_whilo_reg ? wb_hi_reg : hi_reg;
    lo_rd = wb_whilo_reg ? wb_lo_reg : lo_reg;
  end

  assign wb_valid = wb_valid_reg;
  assign wb_wd    = wb_wd_reg;
  assign wb_wreg  = wb_wreg_reg;
  assign wb_wdata = wb_wdata_reg;
  assign wb_whilo = wb_whilo_reg;
  assign wb_hi    = wb_hi_reg;
  assign wb_lo    = wb_lo_reg;
  assign instret  = instret_reg;

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Scoreboard bench for mem_wb_hilo: stimulus queues the expected post-edge WB state,
// a monitor compares it just after each rising edge. Small CNT_W makes the wrap reachable.
module tb_mem_wb_hilo;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall_mem = 1'b0, stall_wb = 1'b0, flush = 1'b0;
  logic          mem_valid = 1'b0, mem_wreg = 1'b0, mem_whilo = 1'b0;
  logic [AW-1:0] mem_wd = '0;
  logic [DW-1:0] mem_wdata = '0, mem_hi = '0, mem_lo = '0;
  logic          wb_valid, wb_wreg, wb_whilo;
  logic [AW-1:0] wb_wd;
  logic [DW-1:0] wb_wdata, wb_hi, wb_lo, hi_rd, lo_rd;
  logic [CW-1:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_hilo #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .hi_rd(hi_rd), .lo_rd(lo_rd), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          valid;
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] wdata;
    logic          whilo;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi_rd;
    logic [DW-1:0] lo_rd;
    logic [CW-1:0] instret;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(string n, logic v, logic [AW-1:0] wd, logic wr, logic [DW-1:0] wdt,
                              logic wh, logic [DW-1:0] h, logic [DW-1:0] l,
                              logic [DW-1:0] hr, logic [DW-1:0] lr, logic [CW-1:0] ic);
    exp_t e;
    e.name = n; e.valid = v; e.wd = wd; e.wreg = wr; e.wdata = wdt; e.whilo = wh;
    e.hi = h; e.lo = l; e.hi_rd = hr; e.lo_rd = lr; e.instret = ic;
    return e;
  endfunction

  // Drive MEM inputs from a falling edge, queue the expectation, advance one cycle.
  task automatic step(input logic v, input logic [AW-1:0] wd, input logic wr, input logic [DW-1:0] wdt,
                      input logic wh, input logic [DW-1:0] h, input logic [DW-1:0] l,
                      input logic sm, input logic sw, input logic fl, input exp_t e);
    mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdt;
    mem_whilo = wh; mem_hi = h; mem_lo = l;
    stall_mem = sm; stall_wb = sw; flush = fl;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_zero(input string n);
    n_cmp++;
    if ({wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, hi_rd, lo_rd, instret} !== '0) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h hi_rd=%h lo_rd=%h instret=%0d, expected all zero",
               n, wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, hi_rd, lo_rd, instret);
    end
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, hi_rd, lo_rd, instret} !==
            {e.valid, e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo, e.hi_rd, e.lo_rd, e.instret}) begin
          n_bad++;
          $display("FAIL %s: got valid=%0b wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h hi_rd=%h lo_rd=%h instret=%0d, expected valid=%0b wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h hi_rd=%h lo_rd=%h instret=%0d",
                   e.name, wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, hi_rd, lo_rd, instret,
                   e.valid, e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo, e.hi_rd, e.lo_rd, e.instret);
        end else begin
          $display("ok   %s: wd=%0d wdata=%h hi_rd=%h lo_rd=%h instret=%0d", e.name, wb_wd, wb_wdata, hi_rd, lo_rd, instret);
        end
      end
    end
  end

  localparam logic [DW-1:0] H1 = 32'h1234_5678, L1 = 32'h9ABC_DEF0;
  localparam logic [DW-1:0] H2 = 32'hAAAA_0001, L2 = 32'hBBBB_0002;
  localparam logic [DW-1:0] H3 = 32'hCAFE_0000, L3 = 32'h0000_F00D;

  initial begin : stimulus
    #1;
    check_zero("reset_t0");
    repeat (2) @(negedge clk);
    check_zero("reset_2cyc");
    rst = 1'b1;

    step(1, 3, 1, 32'hAB, 0, 0, 0, 0, 0, 0, mk("capture", 1, 3, 1, 32'hAB, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, 0, 1, H1, L1, 0, 0, 0, mk("hilo_write_through", 1, 0, 0, 0, 1, H1, L1, H1, L1, 1));
    step(0, 7, 1, 32'h55, 1, 1, 2, 0, 0, 0, mk("invalid_is_bubble", 0, 0, 0, 0, 0, 0, 0, H1, L1, 2));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk("hilo_persist", 0, 0, 0, 0, 0, 0, 0, H1, L1, 2));
    step(1, 5, 1, 32'h11, 0, 0, 0, 1, 0, 0, mk("stall_mem_bubble", 0, 0, 0, 0, 0, 0, 0, H1, L1, 2));
    step(1, 6, 1, 32'h66, 1, H2, L2, 0, 0, 0, mk("capture_hilo2", 1, 6, 1, 32'h66, 1, H2, L2, H2, L2, 2));
    for (int i = 0; i < 3; i++)
      step(1, 9, 1, 32'h99, 0, 0, 0, 1, 1, 0, mk("wb_hold", 1, 6, 1, 32'h66, 1, H2, L2, H2, L2, 2));
    step(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, mk("release_r0_write", 1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, H2, L2, 3));
    step(1, 2, 1, 32'h22, 1, H3, L3, 0, 0, 0, mk("capture_hilo3", 1, 2, 1, 32'h22, 1, H3, L3, H3, L3, 4));
    step(1, 8, 1, 32'h88, 1, 5, 6, 1, 1, 1, mk("flush_over_stall", 0, 0, 0, 0, 0, 0, 0, H3, L3, 4));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk("flush_kept_commit", 0, 0, 0, 0, 0, 0, 0, H3, L3, 4));
    for (int k = 1; k <= 12; k++)
      step(1, 1, 1, DW'(k), 0, 0, 0, 0, 0, 0, mk("retire", 1, 1, 1, DW'(k), 0, 0, 0, H3, L3, CW'(3 + k)));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk("instret_wrap", 0, 0, 0, 0, 0, 0, 0, H3, L3, 0));

    step(1, 4, 1, 32'h44, 1, 32'h77, 32'h88, 0, 0, 0, mk("pre_reset", 1, 4, 1, 32'h44, 1, 32'h77, 32'h88, 32'h77, 32'h88, 0));
    step(1, 9, 1, 32'h99, 0, 0, 0, 1, 1, 0, mk("stall_pre_reset", 1, 4, 1, 32'h44, 1, 32'h77, 32'h88, 32'h77, 32'h88, 0));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero("async_reset_midcycle");
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk("held_discarded", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
